// File: rtl/tty_text_engine.sv
// rtl/tty_text_engine.sv - text terminal core: char stream in, cursor and scrolled character store out
// Optional TTY_SCROLL_EN: hardware scrolling via circular row offset instead of page clear.
module tty_text_engine #(
    parameter int COLS      = 40,
    parameter int ROWS      = 30,
    parameter int TAB_W     = 4,
    parameter int BLINK_DIV = 12500000,
    parameter int CW        = $clog2(COLS),
    parameter int RW        = $clog2(ROWS)
) (
    input  logic          clk_25mhz,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    input  logic [CW-1:0] rd_col,
    input  logic [RW-1:0] rd_row,
    output logic [7:0]    rd_char,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] cur_row,
    output logic          cur_on,
    output logic          busy
);
    localparam int            BW       = $clog2(BLINK_DIV + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW:0]   COLS_X   = (CW + 1)'(COLS);
    localparam logic [CW:0]   TAB_X    = (CW + 1)'(TAB_W);

    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;

    state_t        state, state_n;
    logic [RW-1:0] top, top_n, row_n, clr_row, clr_row_n;
    logic [CW-1:0] col_n, clr_col, clr_col_n;
    logic [BW-1:0] blink_cnt;
    logic          we, adv;
    logic [RW-1:0] we_row, cur_phys, prev_phys, last_phys, rd_phys;
    logic [CW-1:0] we_col;
    logic [7:0]    we_data;
    logic [CW:0]   tab_next;
    logic [7:0]    mem [ROWS][COLS];

    // Logical-to-physical row mapping through the circular top offset, without a modulo.
    function automatic logic [RW-1:0] phys(input logic [RW-1:0] lr, input logic [RW-1:0] t);
        logic [RW:0] s;
        s = {1'b0, lr} + {1'b0, t};
        if (s >= (RW + 1)'(ROWS))
            s = s - (RW + 1)'(ROWS);
        return s[RW-1:0];
    endfunction

    assign cur_phys  = phys(cur_row, top);
    assign prev_phys = (cur_phys == '0) ? ROW_LAST : cur_phys - 1'b1;
    assign last_phys = phys(ROW_LAST, top);
    assign rd_phys   = phys(rd_row, top);
    assign tab_next  = ({1'b0, cur_col} & ~(TAB_X - 1'b1)) + TAB_X;
    assign wr_ready  = (state == IDLE);
    assign busy      = ~wr_ready;

    always_comb begin
        state_n   = state;
        top_n     = top;
        col_n     = cur_col;
        row_n     = cur_row;
        clr_col_n = clr_col;
        clr_row_n = clr_row;
        we        = 1'b0;
        we_row    = clr_row;
        we_col    = clr_col;
        we_data   = 8'h00;
        adv       = 1'b0;
        case (state)
            CLR_ALL: begin
                we = 1'b1;
                if (clr_col == COL_LAST) begin
                    clr_col_n = '0;
                    if (clr_row == ROW_LAST) begin
                        clr_row_n = '0;
                        state_n   = IDLE;
                        top_n     = '0;
                        col_n     = '0;
                        row_n     = '0;
                    end else begin
                        clr_row_n = clr_row + 1'b1;
                    end
                end else begin
                    clr_col_n = clr_col + 1'b1;
                end
            end
            CLR_LINE: begin
                we     = 1'b1;
                we_row = last_phys;
                if (clr_col == COL_LAST) begin
                    clr_col_n = '0;
                    state_n   = IDLE;
                end else begin
                    clr_col_n = clr_col + 1'b1;
                end
            end
            IDLE: begin
                if (wr_valid) begin
                    case (wr_data)
                        8'h0D: begin
                            col_n = '0;
                            adv   = 1'b1;
                        end
                        8'h08: begin
                            if (cur_col != '0) begin
                                col_n  = cur_col - 1'b1;
                                we     = 1'b1;
                                we_row = cur_phys;
                                we_col = cur_col - 1'b1;
                            end else if (cur_row != '0) begin
                                row_n  = cur_row - 1'b1;
                                col_n  = COL_LAST;
                                we     = 1'b1;
                                we_row = prev_phys;
                                we_col = COL_LAST;
                            end
                        end
                        8'h09: begin
                            if (tab_next >= COLS_X) begin
                                col_n = '0;
                                adv   = 1'b1;
                            end else begin
                                col_n = tab_next[CW-1:0];
                            end
                        end
                        8'h1B: state_n = CLR_ALL;
                        default: begin
                            we      = 1'b1;
                            we_row  = cur_phys;
                            we_col  = cur_col;
                            we_data = wr_data;
                            if (cur_col == COL_LAST) begin
                                col_n = '0;
                                adv   = 1'b1;
                            end else begin
                                col_n = cur_col + 1'b1;
                            end
                        end
                    endcase
                    if (adv) begin
                        if (cur_row != ROW_LAST) begin
                            row_n = cur_row + 1'b1;
                        end else begin
`ifdef TTY_SCROLL_EN
                            top_n   = (top == ROW_LAST) ? '0 : top + 1'b1;
                            state_n = CLR_LINE;
`else
                            state_n = CLR_ALL;
`endif
                        end
                    end
                end
            end
            default: state_n = CLR_ALL;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state   <= CLR_ALL;
            top     <= '0;
            cur_col <= '0;
            cur_row <= '0;
            clr_col <= '0;
            clr_row <= '0;
        end else begin
            state   <= state_n;
            top     <= top_n;
            cur_col <= col_n;
            cur_row <= row_n;
            clr_col <= clr_col_n;
            clr_row <= clr_row_n;
        end
    end

    // Any accepted byte restarts the blink phase with the cursor visible.
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            blink_cnt <= '0;
            cur_on    <= 1'b0;
        end else if (wr_valid && wr_ready) begin
            blink_cnt <= '0;
            cur_on    <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            cur_on    <= ~cur_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (we && !rst)
            mem[we_row][we_col] <= we_data;
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst)
            rd_char <= 8'h00;
        else
            rd_char <= mem[rd_phys][rd_col];
    end
endmodule

// File: tb/tb_tty_text_engine.sv
// tb/tb_tty_text_engine.sv - randomized bench for tty_text_engine against a logical-screen model
module tb_tty_text_engine;
    localparam int COLS      = 40;
    localparam int ROWS      = 30;
    localparam int TAB_W     = 4;
    localparam int BLINK_DIV = 64;
    localparam int CW        = $clog2(COLS);
    localparam int RW        = $clog2(ROWS);

    logic          clk_25mhz = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_ready;
    logic [CW-1:0] rd_col = '0;
    logic [RW-1:0] rd_row = '0;
    logic [7:0]    rd_char;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          cur_on;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] scr [ROWS][COLS];
    int mcol = 0;
    int mrow = 0;

    tty_text_engine #(.COLS(COLS), .ROWS(ROWS), .TAB_W(TAB_W), .BLINK_DIV(BLINK_DIV)) dut (
        .clk_25mhz(clk_25mhz), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_col(rd_col), .rd_row(rd_row), .rd_char(rd_char),
        .cur_col(cur_col), .cur_row(cur_row), .cur_on(cur_on), .busy(busy)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    initial begin
        #(40 * 100000);
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    function automatic void clear_model();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h00;
        mcol = 0;
        mrow = 0;
    endfunction

    // Returns how many cycles the engine is expected to stay busy after the byte.
    function automatic int advance();
        if (mrow < ROWS - 1) begin
            mrow++;
            return 0;
        end
`ifdef TTY_SCROLL_EN
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = scr[r+1][c];
        for (int c = 0; c < COLS; c++)
            scr[ROWS-1][c] = 8'h00;
        return COLS;
`else
        clear_model();
        return COLS * ROWS;
`endif
    endfunction

    function automatic int model_apply(input logic [7:0] b);
        int t;
        case (b)
            8'h0D: begin
                mcol = 0;
                return advance();
            end
            8'h08: begin
                if (mcol > 0) begin
                    mcol--;
                    scr[mrow][mcol] = 8'h00;
                end else if (mrow > 0) begin
                    mrow--;
                    mcol = COLS - 1;
                    scr[mrow][mcol] = 8'h00;
                end
                return 0;
            end
            8'h09: begin
                t = (mcol / TAB_W + 1) * TAB_W;
                if (t >= COLS) begin
                    mcol = 0;
                    return advance();
                end
                mcol = t;
                return 0;
            end
            8'h1B: begin
                clear_model();
                return COLS * ROWS;
            end
            default: begin
                scr[mrow][mcol] = b;
                mcol++;
                if (mcol == COLS) begin
                    mcol = 0;
                    return advance();
                end
                return 0;
            end
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int exp_busy;
        int cnt;
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before_send: wr_ready=%b required 1 (byte %02h)", wr_ready, b);
        end
        exp_busy = model_apply(b);
        wr_valid = 1'b1;
        wr_data  = b;
        @(negedge clk_25mhz);
        wr_valid = 1'b0;
        cnt = 0;
        while (busy !== 1'b0 && cnt < 3000) begin
            cnt++;
            @(negedge clk_25mhz);
        end
        vectors++;
        if (cnt != exp_busy) begin
            miscompares++;
            $display("FAIL busy_cycles: got %0d required %0d (byte %02h)", cnt, exp_busy, b);
        end
        vectors++;
        if (cur_col !== CW'(mcol) || cur_row !== RW'(mrow)) begin
            miscompares++;
            $display("FAIL cursor: got (%0d,%0d) required (%0d,%0d) after byte %02h",
                     cur_row, cur_col, mrow, mcol, b);
        end
    endtask

    task automatic read_cell(input int r, input int c, output logic [7:0] v);
        rd_row = RW'(r);
        rd_col = CW'(c);
        @(negedge clk_25mhz);
        v = rd_char;
    endtask

    task automatic check_screen(input string tag);
        logic [7:0] v;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c, v);
                vectors++;
                if (v !== scr[r][c]) begin
                    miscompares++;
                    $display("FAIL screen_%s: cell (%0d,%0d) got %02h required %02h",
                             tag, r, c, v, scr[r][c]);
                end
            end
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1;
        wr_valid = 1'b0;
        repeat (3) @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        vectors++;
        if (busy !== 1'b1 || wr_ready !== 1'b0 || cur_col !== '0 || cur_row !== '0 ||
            cur_on !== 1'b0 || rd_char !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_values: busy=%b ready=%b col=%0d row=%0d on=%b rd=%02h required 1 0 0 0 0 00",
                     busy, wr_ready, cur_col, cur_row, cur_on, rd_char);
        end
        rst = 1'b0;
        clear_model();
        cnt = 0;
        while (busy !== 1'b0 && cnt < 3000) begin
            cnt++;
            @(negedge clk_25mhz);
        end
        vectors++;
        if (cnt != COLS * ROWS) begin
            miscompares++;
            $display("FAIL reset_clear_cycles: got %0d required %0d", cnt, COLS * ROWS);
        end
        check_screen("reset");
    endtask

    task automatic test_backspace();
        logic [7:0] v;
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h08);
        vectors++;
        if (cur_col !== CW'(1)) begin
            miscompares++;
            $display("FAIL bs_col: got %0d required 1", cur_col);
        end
        read_cell(0, 0, v);
        vectors++;
        if (v !== 8'h41) begin
            miscompares++;
            $display("FAIL bs_cell00: got %02h required 41", v);
        end
        read_cell(0, 1, v);
        vectors++;
        if (v !== 8'h00) begin
            miscompares++;
            $display("FAIL bs_cell01: got %02h required 00", v);
        end
        send_byte(8'h08);
        send_byte(8'h08);
        vectors++;
        if (cur_col !== '0 || cur_row !== '0) begin
            miscompares++;
            $display("FAIL bs_origin: got (%0d,%0d) required (0,0)", cur_row, cur_col);
        end
    endtask

    task automatic test_tab();
        send_byte(8'h41);
        send_byte(8'h09);
        vectors++;
        if (cur_col !== CW'(4)) begin
            miscompares++;
            $display("FAIL tab_col1: got %0d required 4", cur_col);
        end
        while (mcol < 37)
            send_byte(8'($urandom_range(8'h20, 8'h7E)));
        send_byte(8'h09);
        vectors++;
        if (cur_col !== '0 || cur_row !== RW'(1)) begin
            miscompares++;
            $display("FAIL tab_wrap: got (%0d,%0d) required (1,0)", cur_row, cur_col);
        end
    endtask

    task automatic test_read_during_write();
        logic [7:0] old;
        rd_row = RW'(mrow);
        rd_col = CW'(mcol);
        old = scr[mrow][mcol];
        send_byte(8'h5A);
        vectors++;
        if (rd_char !== old) begin
            miscompares++;
            $display("FAIL rdw_old: got %02h required %02h", rd_char, old);
        end
        @(negedge clk_25mhz);
        vectors++;
        if (rd_char !== 8'h5A) begin
            miscompares++;
            $display("FAIL rdw_new: got %02h required 5a", rd_char);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      send_byte(8'($urandom_range(8'h20, 8'h7E)));
            else if (r < 80) send_byte(8'h0D);
            else if (r < 90) send_byte(8'h08);
            else             send_byte(8'h09);
        end
        check_screen("random");
    endtask

    task automatic test_scroll();
        int len;
        send_byte(8'h1B);
        for (int line = 0; line < ROWS; line++) begin
            len = $urandom_range(1, COLS - 1);
            for (int k = 0; k < len; k++)
                send_byte(8'($urandom_range(8'h20, 8'h7E)));
            send_byte(8'h0D);
        end
        vectors++;
`ifdef TTY_SCROLL_EN
        if (cur_row !== RW'(ROWS - 1) || cur_col !== '0) begin
            miscompares++;
            $display("FAIL scroll_cursor: got (%0d,%0d) required (%0d,0)", cur_row, cur_col, ROWS - 1);
        end
`else
        if (cur_row !== '0 || cur_col !== '0) begin
            miscompares++;
            $display("FAIL page_cursor: got (%0d,%0d) required (0,0)", cur_row, cur_col);
        end
`endif
        check_screen("fill");
        for (int line = 0; line < 35; line++) begin
            len = $urandom_range(0, COLS + 5);
            for (int k = 0; k < len; k++)
                send_byte(8'($urandom_range(8'h20, 8'h7E)));
            send_byte(8'h0D);
        end
        check_screen("wrap");
    endtask

    task automatic test_blink();
        logic exp_on;
        send_byte(8'h78);
        for (int k = 0; k < 3 * BLINK_DIV + BLINK_DIV / 2; k++) begin
            exp_on = ((k / BLINK_DIV) % 2) == 0;
            vectors++;
            if (cur_on !== exp_on) begin
                miscompares++;
                $display("FAIL blink_phase: cycle %0d got %b required %b", k, cur_on, exp_on);
            end
            @(negedge clk_25mhz);
        end
        send_byte(8'h78);
        vectors++;
        if (cur_on !== 1'b1) begin
            miscompares++;
            $display("FAIL blink_reload: got %b required 1", cur_on);
        end
    endtask

    initial begin
        @(negedge clk_25mhz);
        test_reset();
        test_backspace();
        test_tab();
        test_read_during_write();
        test_random();
        test_scroll();
        test_blink();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tty_text_engine.md
# tty_text_engine

Parametrised text-terminal core for the TTY display path: accepts a character stream over a valid/ready handshake, interprets control codes, maintains the cursor and a COLS×ROWS character store, and serves a one-cycle-latency character fetch port to the VGA glyph renderer. It replaces fixed 40×30 page-flipping with hardware scrolling through a circular row offset, and adds automatic screen clearing and a cursor blink phase.

## Interface
- COLS, 40, characters per row (2..128)
- ROWS, 30, character rows (2..64)
- TAB_W, 4, tab stop spacing, power of two
- BLINK_DIV, 12500000, cycles per cursor blink half-period
- CW, $clog2(COLS), column index width (derived)
- RW, $clog2(ROWS), row index width (derived)

- clk_25mhz  in  1  pixel clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  character present
- wr_data  in  8  character code
- wr_ready  out  1  block can accept; transfer when wr_valid & wr_ready
- rd_col  in  CW  display fetch column (logical)
- rd_row  in  RW  display fetch row (logical, 0 = top of screen)
- rd_char  out  8  character at (rd_row, rd_col), registered
- cur_col  out  CW  cursor column
- cur_row  out  RW  cursor logical row
- cur_on  out  1  cursor blink phase, 1 = draw cursor
- busy  out  1  clear sequence in progress (= ~wr_ready)

## Operation
- States: CLR_ALL, IDLE, CLR_LINE. Reset → CLR_ALL.
- Physical row = (logical row + top) mod ROWS; top is an RW-bit register.
- CLR_ALL: writes 0x00 to every cell, one per cycle (COLS×ROWS cycles), then top=0, cursor=(0,0), → IDLE.
- CLR_LINE: writes 0x00 to the COLS cells of physical row (top+ROWS-1) mod ROWS, then → IDLE.
- IDLE, accepted byte decoded:
  - 0x0D: col=0, line-advance.
  - 0x08: if col>0: col-1, write 0x00 at new position; if col=0,row>0: row-1, col=COLS-1, write 0x00 there; at (0,0): no effect.
  - 0x09: col=(col/TAB_W+1)·TAB_W; if ≥COLS: col=0, line-advance. No write.
  - 0x1B: → CLR_ALL.
  - any other code: write at cursor, col+1; if col reaches COLS: col=0, line-advance.
- Line-advance: if row<ROWS-1: row+1; else scroll (see Configuration).
- Blink: counter counts to BLINK_DIV-1 then toggles cur_on; any accepted byte reloads counter to 0 and forces cur_on=1.

## Timing
- Reset values: cur_col=0, cur_row=0, cur_on=0, rd_char=0x00, wr_ready=0, busy=1, top=0.
- wr_ready=1 only in IDLE; back-to-back acceptance every cycle in IDLE.
- Character write to store occurs in the accept cycle; cursor outputs update the next cycle.
- Scrolling byte or 0x1B: wr_ready drops the cycle after acceptance; CLR_LINE lasts exactly COLS cycles, CLR_ALL exactly COLS×ROWS.
- rd_char valid one cycle after rd_row/rd_col; read port independent of writes; same-cycle read/write to one cell returns old data.
- Reset asserted mid-clear restarts CLR_ALL from cell 0.
- All column/row arithmetic is modulo-free compare-and-wrap; no out-of-range index is ever written.

## Configuration
- TTY_SCROLL_EN defined: line-advance at row ROWS-1 keeps row, increments top mod ROWS, enters CLR_LINE.
- TTY_SCROLL_EN undefined: line-advance at row ROWS-1 enters CLR_ALL (page mode); top stays 0.

## Test plan
- Reset, hold rst 3 cycles → busy=1 for COLS×ROWS=1200 cycles, then wr_ready=1, all rd_char reads 0x00.
- Send "AB" then 0x08 → (0,0)=0x41, (0,1)=0x00, cur_col=1; 0x08 at (0,0) → no change.
- Send 0x09 from col 1 → cur_col=4; from col 37 → cur_col=0, cur_row+1.
- With TTY_SCROLL_EN: fill 30 lines then 0x0D at row 29 → busy 40 cycles, former row 1 reads at logical row 0, row 29 all 0x00, cur_row=29.
- Without TTY_SCROLL_EN: same stimulus → busy 1200 cycles, cursor (0,0), screen blank.
- No writes for 2×BLINK_DIV cycles → cur_on toggles twice; write 'x' → cur_on=1 next cycle.
